// File: rtl/sdram_burst_reader.sv
// Splits a word transfer into row-aligned SDRAM read bursts and streams the returned beats out of a FWFT FIFO.
// Latency: start->rd_request 3 cycles, beat->out_valid 1 cycle; a burst is requested only once the FIFO can hold all of it.
module sdram_burst_reader #(
   parameter int FIFO_DEPTH = 512,
   parameter int MAX_BURST  = 256
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [22:0]                   base_address,
   input  logic [8:0]                    word_count,
   output logic                          busy,
   output logic                          done,
   output logic                          rd_request,
   output logic [22:0]                   rd_address,
   output logic [8:0]                    rd_burst_length,
   input  logic                          rd_available,
   input  logic [31:0]                   rd_data,
   output logic                          out_valid,
   output logic [31:0]                   out_data,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_PLAN    = 2'd1;
   localparam logic [1:0] S_REQUEST = 2'd2;
   localparam logic [1:0] S_RECEIVE = 2'd3;

   localparam logic [8:0]    MAX_CHUNK = 9'(MAX_BURST);
   localparam logic [LW-1:0] DEPTH_W   = LW'(FIFO_DEPTH);

   logic [1:0]    state;
   logic [22:0]   addr;
   logic [8:0]    remaining;
   logic [8:0]    chunk;
   logic [8:0]    beats_left;
   logic          zero_done;

   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic [8:0]    row_room;
   logic [8:0]    chunk_c;
   logic [LW-1:0] free_words;
   logic          push;
   logic          pop;
   logic          last_beat;

   // Words left before the current 1 KB row ends.
   assign row_room = 9'd256 - {1'b0, addr[9:2]};

   always_comb begin
      chunk_c = remaining;
      if (row_room < chunk_c)
         chunk_c = row_room;
      if (MAX_CHUNK < chunk_c)
         chunk_c = MAX_CHUNK;
   end

   assign push       = (state == S_RECEIVE) && rd_available;
   assign pop        = out_valid && out_ready;
   assign last_beat  = push && (beats_left == 9'd1);
   assign free_words = DEPTH_W - fifo_level;

   // Final-transfer done coincides with the push of the last word.
   assign done      = zero_done | (last_beat && (remaining == chunk));
   assign out_valid = (fifo_level != '0);
   assign out_data  = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= S_IDLE;
         addr            <= '0;
         remaining       <= '0;
         chunk           <= '0;
         beats_left      <= '0;
         zero_done       <= 1'b0;
         busy            <= 1'b0;
         rd_request      <= 1'b0;
         rd_address      <= '0;
         rd_burst_length <= '0;
      end else begin
         rd_request <= 1'b0;
         zero_done  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (word_count == 9'd0) begin
                     zero_done <= 1'b1;
                  end else begin
                     addr      <= base_address & ~23'd3;
                     remaining <= word_count;
                     busy      <= 1'b1;
                     state     <= S_PLAN;
                  end
               end
            end
            S_PLAN: begin
               rd_address      <= addr;
               rd_burst_length <= chunk_c - 9'd1;
               chunk           <= chunk_c;
               beats_left      <= chunk_c;
               state           <= S_REQUEST;
            end
            S_REQUEST: begin
               // Only one burst is ever outstanding, so the level alone bounds the space needed.
               if (free_words >= LW'(chunk)) begin
                  rd_request <= 1'b1;
                  state      <= S_RECEIVE;
               end
            end
            S_RECEIVE: begin
               if (push) begin
                  beats_left <= beats_left - 9'd1;
                  if (beats_left == 9'd1) begin
                     remaining <= remaining - chunk;
                     addr      <= addr + {12'd0, chunk, 2'b00};
                     if (remaining == chunk) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                     end else begin
                        state <= S_PLAN;
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= rd_data;
   end

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Bench for sdram_burst_reader: a controller model answers requests, a reference model
// derives the expected bursts and word stream from the row-split rule.
`timescale 1ns/1ps
module tb_sdram_burst_reader;

   localparam int DEPTH = 256;
   localparam int MAXB  = 256;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     start;
   logic [22:0]              base_address;
   logic [8:0]               word_count;
   logic                     busy;
   logic                     done;
   logic                     rd_request;
   logic [22:0]              rd_address;
   logic [8:0]               rd_burst_length;
   logic                     rd_available;
   logic [31:0]              rd_data;
   logic                     out_valid;
   logic [31:0]              out_data;
   logic                     out_ready;
   logic [$clog2(DEPTH):0]   fifo_level;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int start_cyc = 0;

   logic [22:0] req_addr_q[$];
   logic [8:0]  req_len_q[$];
   int          req_cyc_q[$];
   int          req_lvl_q[$];
   logic [31:0] pop_q[$];
   logic [22:0] exp_addr_q[$];
   logic [8:0]  exp_len_q[$];
   logic [31:0] exp_data_q[$];

   int   done_cnt = 0;
   int   overflow_cnt = 0;
   int   busy_hi = 0;
   int   neg_level = 0;
   int   first_beat_cyc = -1;
   int   first_valid_cyc = -1;
   logic done_beat = 1'b0;
   int   ready_mode = 1;
   bit   gap_en = 1'b1;
   logic [22:0] resp_addr = '0;
   int   resp_left = 0;

   sdram_burst_reader #(.FIFO_DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
      .clk(clk), .rst(rst), .start(start), .base_address(base_address),
      .word_count(word_count), .busy(busy), .done(done), .rd_request(rd_request),
      .rd_address(rd_address), .rd_burst_length(rd_burst_length),
      .rd_available(rd_available), .rd_data(rd_data), .out_valid(out_valid),
      .out_data(out_data), .out_ready(out_ready), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_word(input logic [22:0] a);
      return ({9'd0, a} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // Controller model: after a request, return L+1 beats in address order with random gaps.
   initial begin
      rd_available = 1'b0;
      rd_data = '0;
      forever begin
         @(posedge clk); #1;
         rd_available = 1'b0;
         if (rd_request) begin
            req_addr_q.push_back(rd_address);
            req_len_q.push_back(rd_burst_length);
            req_cyc_q.push_back(cyc);
            req_lvl_q.push_back(neg_level);
            resp_addr = rd_address;
            resp_left = int'(rd_burst_length) + 1;
         end else if (resp_left > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
            rd_available = 1'b1;
            rd_data = mem_word(resp_addr);
            resp_addr = resp_addr + 23'd4;
            resp_left--;
         end
      end
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge clk) begin
      neg_level = int'(fifo_level);
      if (out_valid && out_ready) pop_q.push_back(out_data);
      if (done) begin
         done_cnt++;
         done_beat = rd_available;
      end
      if (rd_available && busy && int'(fifo_level) == DEPTH) overflow_cnt++;
      if (busy) busy_hi++;
      if (rd_available && busy && first_beat_cyc < 0) first_beat_cyc = cyc;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
   end

   // Reference: words are consecutive addresses; bursts follow the min(remaining, row room, MAX) rule.
   task automatic build_model(input logic [22:0] base, input int count);
      int a, rem, col, c;
      a = int'(base) & ~3;
      for (int i = 0; i < count; i++) exp_data_q.push_back(mem_word(23'(a + 4 * i)));
      rem = count;
      while (rem > 0) begin
         col = (a / 4) % 256;
         c = rem;
         if (256 - col < c) c = 256 - col;
         if (MAXB < c) c = MAXB;
         exp_addr_q.push_back(23'(a));
         exp_len_q.push_back(9'(c - 1));
         a = (a + 4 * c) % (1 << 23);
         rem -= c;
      end
   endtask

   task automatic clear_all();
      req_addr_q.delete(); req_len_q.delete(); req_cyc_q.delete(); req_lvl_q.delete();
      pop_q.delete(); exp_addr_q.delete(); exp_len_q.delete(); exp_data_q.delete();
      done_cnt = 0; overflow_cnt = 0; busy_hi = 0; done_beat = 1'b0;
      first_beat_cyc = -1; first_valid_cyc = -1;
   endtask

   function automatic int stream_diff();
      int n;
      n = (pop_q.size() < exp_data_q.size()) ? pop_q.size() : exp_data_q.size();
      for (int i = 0; i < n; i++) if (pop_q[i] !== exp_data_q[i]) return i;
      if (pop_q.size() != exp_data_q.size()) return n;
      return -1;
   endfunction

   function automatic int req_diff();
      int n;
      n = (req_addr_q.size() < exp_addr_q.size()) ? req_addr_q.size() : exp_addr_q.size();
      for (int i = 0; i < n; i++)
         if (req_addr_q[i] !== exp_addr_q[i] || req_len_q[i] !== exp_len_q[i]) return i;
      if (req_addr_q.size() != exp_addr_q.size()) return n;
      return -1;
   endfunction

   task automatic pulse_start(input logic [22:0] b, input int n);
      @(posedge clk); #1;
      base_address = b; word_count = 9'(n); start = 1'b1; start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_drain(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (pop_q.size() >= n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      total++; if ({busy, done, rd_request, out_valid} !== 4'b0) begin bad++;
         $display("FAIL reset_flags got %b want 0000", {busy, done, rd_request, out_valid}); end
      total++; if (rd_address !== 23'd0) begin bad++;
         $display("FAIL reset_rd_address got %h want 0", rd_address); end
      total++; if (rd_burst_length !== 9'd0) begin bad++;
         $display("FAIL reset_burst_length got %0d want 0", rd_burst_length); end
      total++; if (fifo_level !== '0) begin bad++;
         $display("FAIL reset_fifo_level got %0d want 0", fifo_level); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_single();
      bit ok, dr;
      int d;
      clear_all();
      ready_mode = 0;
      build_model(23'h000100, 16);
      pulse_start(23'h000100, 16);
      wait_done(2000, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_done timeout got %0d want 1", ok); end
      wait_drain(16, 500, dr);
      repeat (3) @(negedge clk);
      d = req_diff();
      total++; if (d != -1) begin bad++;
         $display("FAIL single_requests first bad %0d got %0d reqs want %0d", d, req_addr_q.size(), exp_addr_q.size()); end
      d = stream_diff();
      total++; if (d != -1) begin bad++;
         $display("FAIL single_stream first bad %0d got %0d words want %0d", d, pop_q.size(), exp_data_q.size()); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL single_done_count got %0d want 1", done_cnt); end
      total++; if (done_beat !== 1'b1) begin bad++;
         $display("FAIL single_done_with_last_beat got %b want 1", done_beat); end
      total++; if (req_cyc_q.size() < 1 || req_cyc_q[0] - start_cyc != 3) begin bad++;
         $display("FAIL single_req_latency got %0d want 3", req_cyc_q.size() ? req_cyc_q[0] - start_cyc : -1); end
      total++; if (first_valid_cyc - first_beat_cyc != 1) begin bad++;
         $display("FAIL single_valid_latency got %0d want 1", first_valid_cyc - first_beat_cyc); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got %b want 0", busy); end
   endtask

   task automatic test_row_split();
      bit ok, dr;
      int d;
      clear_all();
      ready_mode = 2;
      build_model(23'h0003C0, 40);
      pulse_start(23'h0003C0, 40);
      wait_done(2000, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL split_done timeout got %0d want 1", ok); end
      wait_drain(40, 1000, dr);
      repeat (3) @(negedge clk);
      d = req_diff();
      total++; if (d != -1) begin bad++;
         $display("FAIL split_requests first bad %0d got %0d reqs want %0d", d, req_addr_q.size(), exp_addr_q.size()); end
      d = stream_diff();
      total++; if (d != -1) begin bad++;
         $display("FAIL split_stream first bad %0d got %0d words want %0d", d, pop_q.size(), exp_data_q.size()); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL split_done_count got %0d want 1", done_cnt); end
   endtask

   task automatic test_backpressure();
      bit ok1, ok2, dr;
      int d;
      clear_all();
      ready_mode = 1;
      build_model(23'h000000, 200);
      build_model(23'h001000, 200);
      pulse_start(23'h000000, 200);
      wait_done(3000, ok1);
      total++; if (ok1 !== 1'b1) begin bad++; $display("FAIL bp_first_done timeout got %0d want 1", ok1); end
      repeat (5) @(negedge clk);
      total++; if (int'(fifo_level) != 200) begin bad++;
         $display("FAIL bp_level_full got %0d want 200", fifo_level); end
      pulse_start(23'h001000, 200);
      repeat (30) @(negedge clk);
      total++; if (req_addr_q.size() != 1) begin bad++;
         $display("FAIL bp_withheld got %0d reqs want 1", req_addr_q.size()); end
      ready_mode = 0;
      wait_done(3000, ok2);
      total++; if (ok2 !== 1'b1) begin bad++; $display("FAIL bp_second_done timeout got %0d want 1", ok2); end
      wait_drain(400, 1000, dr);
      repeat (3) @(negedge clk);
      d = req_diff();
      total++; if (d != -1) begin bad++;
         $display("FAIL bp_requests first bad %0d got %0d reqs want %0d", d, req_addr_q.size(), exp_addr_q.size()); end
      total++; if (req_lvl_q.size() < 2 || req_lvl_q[1] != 56) begin bad++;
         $display("FAIL bp_release_level got %0d want 56", req_lvl_q.size() > 1 ? req_lvl_q[1] : -1); end
      d = stream_diff();
      total++; if (d != -1) begin bad++;
         $display("FAIL bp_stream first bad %0d got %0d words want %0d", d, pop_q.size(), exp_data_q.size()); end
      total++; if (overflow_cnt != 0) begin bad++; $display("FAIL bp_overflow got %0d want 0", overflow_cnt); end
      total++; if (done_cnt != 2) begin bad++; $display("FAIL bp_done_count got %0d want 2", done_cnt); end
   endtask

   task automatic test_zero();
      logic d0, d1, d2;
      clear_all();
      @(posedge clk); #1;
      base_address = 23'h000200; word_count = 9'd0; start = 1'b1;
      @(negedge clk); d0 = done;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk); d1 = done;
      @(negedge clk); d2 = done;
      repeat (8) @(negedge clk);
      total++; if ({d0, d1, d2} !== 3'b010) begin bad++;
         $display("FAIL zero_done_pulse got %b want 010", {d0, d1, d2}); end
      total++; if (busy_hi != 0) begin bad++; $display("FAIL zero_busy got %0d cycles want 0", busy_hi); end
      total++; if (req_addr_q.size() != 0) begin bad++;
         $display("FAIL zero_requests got %0d want 0", req_addr_q.size()); end
   endtask

   task automatic test_wrap_ignore();
      bit ok, dr;
      int d;
      clear_all();
      ready_mode = 0;
      build_model(23'h7FFFF0, 8);
      pulse_start(23'h7FFFF0, 8);
      @(posedge clk);
      pulse_start(23'h000100, 5);
      wait_done(2000, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL wrap_done timeout got %0d want 1", ok); end
      wait_drain(8, 500, dr);
      repeat (15) @(negedge clk);
      d = req_diff();
      total++; if (d != -1) begin bad++;
         $display("FAIL wrap_requests first bad %0d got %0d reqs want %0d", d, req_addr_q.size(), exp_addr_q.size()); end
      d = stream_diff();
      total++; if (d != -1) begin bad++;
         $display("FAIL wrap_stream first bad %0d got %0d words want %0d", d, pop_q.size(), exp_data_q.size()); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL wrap_done_count got %0d want 1", done_cnt); end
   endtask

   task automatic test_reset_mid();
      int n, pre_level;
      bit seen;
      clear_all();
      ready_mode = 1;
      pulse_start(23'h002000, 16);
      n = 0; seen = 1'b0;
      for (int i = 0; i < 500 && !seen; i++) begin
         @(negedge clk);
         if (rd_available) n++;
         if (n == 5) seen = 1'b1;
      end
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL rmid_beats timeout got %0d want 5", n); end
      @(posedge clk); #1;
      pre_level = int'(fifo_level);
      total++; if (pre_level != 5) begin bad++; $display("FAIL rmid_pre_level got %0d want 5", pre_level); end
      rst = 1'b1;
      #1;
      total++; if (fifo_level !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin bad++;
         $display("FAIL rmid_immediate got level=%0d valid=%b busy=%b want 0/0/0", fifo_level, out_valid, busy); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      ready_mode = 2;
      repeat (40) @(negedge clk);
      total++; if (fifo_level !== '0 || out_valid !== 1'b0) begin bad++;
         $display("FAIL rmid_strays got level=%0d valid=%b want 0/0", fifo_level, out_valid); end
      total++; if (done_cnt != 0) begin bad++; $display("FAIL rmid_done got %0d want 0", done_cnt); end
      total++; if (req_addr_q.size() != 1) begin bad++;
         $display("FAIL rmid_requests got %0d want 1", req_addr_q.size()); end
   endtask

   task automatic test_random();
      bit ok, dr;
      int d, cnt;
      logic [22:0] b;
      for (int it = 0; it < 6; it++) begin
         clear_all();
         b = 23'($urandom);
         if (it % 2 == 0) b[9:2] = 8'($urandom_range(200, 255));
         cnt = $urandom_range(1, 256);
         ready_mode = $urandom_range(0, 2);
         build_model(b, cnt);
         pulse_start(b, cnt);
         wait_done(3000, ok);
         total++; if (ok !== 1'b1) begin bad++; $display("FAIL rand%0d_done timeout got %0d want 1", it, ok); end
         ready_mode = 0;
         wait_drain(cnt, 1000, dr);
         repeat (3) @(negedge clk);
         d = req_diff();
         total++; if (d != -1) begin bad++;
            $display("FAIL rand%0d_requests base=%h n=%0d first bad %0d got %0d reqs want %0d",
                     it, b, cnt, d, req_addr_q.size(), exp_addr_q.size()); end
         d = stream_diff();
         total++; if (d != -1) begin bad++;
            $display("FAIL rand%0d_stream base=%h n=%0d first bad %0d got %0d words want %0d",
                     it, b, cnt, d, pop_q.size(), exp_data_q.size()); end
         total++; if (done_cnt != 1 || overflow_cnt != 0) begin bad++;
            $display("FAIL rand%0d_done_ovf got done=%0d ovf=%0d want 1/0", it, done_cnt, overflow_cnt); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; start = 1'b0; base_address = '0; word_count = '0;
      test_reset();
      test_single();
      test_row_split();
      test_backpressure();
      test_zero();
      test_wrap_ignore();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sdram_burst_reader.md
Name: sdram_burst_reader

Overview:
- Client-side initiator for the SDRAM controller's read request interface.
- Accepts a transfer command (byte address, word count) and splits it into row-aligned bursts. It drives rd_request/rd_address/rd_burst_length, collects the rd_available/rd_data beats into an internal FIFO, and presents them to a consumer over a valid/ready stream.
- Sits between the controller and display fetch logic (character/line prefetch).

Parameters:
- FIFO_DEPTH, 512, output FIFO depth in 32-bit words; power of two, must be >= 256.
- MAX_BURST, 256, maximum words per burst; range 1..256.

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse that launches a transfer; ignored while busy=1
- base_address  in  23  byte address of the first word; bits [1:0] are ignored (treated as 0)
- word_count  in  9  number of 32-bit words to fetch, 0..256
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last word is written into the FIFO
- rd_request  out  1  one-cycle request pulse to the controller
- rd_address  out  23  burst start byte address; held stable until the burst's last beat
- rd_burst_length  out  9  words-1 of the current burst; held stable with rd_address
- rd_available  in  1  controller beat strobe
- rd_data  in  32  controller beat data
- out_valid  out  1  FIFO not empty
- out_data  out  32  FIFO head word, first-word-fall-through
- out_ready  in  1  consumer accept; a word pops when out_valid & out_ready
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently held in the FIFO

Behaviour:
- Reset values (async): busy=0, done=0, rd_request=0, rd_address=0, rd_burst_length=0, out_valid=0, fifo_level=0. The state machine is in IDLE and the FIFO is empty.
- Burst semantics: one request with rd_burst_length=L returns exactly L+1 beats on rd_available, in address order.
- Address map: row = 1 KB (256 words) at bits [9:2]. A burst never crosses a 1 KB boundary.
  - chunk = min(remaining, 256 - address[9:2], MAX_BURST).
  - After each burst the address advances by chunk*4, wrapping modulo 2^23.
- State machine:
  - IDLE:
    - start=1 and word_count=0: pulse done next cycle. No request is issued, busy stays 0.
    - start=1 and word_count>0: latch the address and count, then go to PLAN. busy=1 from the next cycle.
  - PLAN: compute chunk; register rd_address and rd_burst_length=chunk-1; go to REQUEST.
  - REQUEST: wait until FIFO free space (FIFO_DEPTH - fifo_level) >= chunk. Then assert rd_request for exactly one cycle and go to RECEIVE. Free space is checked against the level only, which is safe because no other burst is outstanding.
  - RECEIVE: every cycle with rd_available=1 pushes rd_data into the FIFO and decrements the beat counter. After beat chunk, reduce remaining by chunk.
    - remaining>0: go to PLAN.
    - otherwise: pulse done in the same cycle as the last push, clear busy next cycle, go to IDLE.
- rd_available is ignored in IDLE, PLAN and REQUEST. Stray beats, e.g. from an in-flight burst across a reset, are dropped.
- FIFO behaviour:
  - Push and pop in the same cycle: level unchanged.
  - Pop when empty: impossible because out_valid=0.
  - Overflow is impossible by construction. The bench must flag any push while full.
- Latency:
  - start to first rd_request: 3 cycles when the FIFO has room.
  - FIFO push to out_valid=1: 1 cycle.
- rd_address and rd_burst_length change only in PLAN.
- Reset mid-transfer: everything returns to reset values immediately. FIFO contents are discarded and no done pulse is issued.

Test Plan:
- Single burst: start, base_address=0x000100, word_count=16, out_ready=1. Expect one rd_request with rd_address=0x000100 and rd_burst_length=15. Model returns 16 beats D0..D15; out_data sequence D0..D15; done once; busy low afterwards.
- Row split: base_address=0x0003C0 (column 240), word_count=40. Expect request 1 at 0x0003C0 with length 15 (16 words). Expect request 2 at 0x000400 with length 23 (24 words). 40 words in order, one done pulse.
- Backpressure: FIFO_DEPTH=256, out_ready=0, two transfers of 200 words. Expect the second rd_request withheld until fifo_level <= 56 after out_ready is raised. No overflow.
- Zero count: start with word_count=0. Expect done pulse, no rd_request, busy never high.
- Wrap and ignore: base_address=0x7FFFF0 (column 252), word_count=8. Expect request at 0x7FFFF0 with length 3, then request at 0x000000 with length 3. A start pulse mid-transfer is ignored.
- Reset mid-RECEIVE: assert rst after 5 of 16 beats; model keeps sending beats. Expect fifo_level=0, out_valid=0, no done, and stray beats not stored.
